// File: rtl/xbar_feeder.sv
// Crossbar toggle-handshake initiator: buffers one upstream vector, holds it on vector_o,
// toggles valid_o_tg after SETUP_CYCLES and waits for the synchronised ready_i_tg toggle.
module xbar_feeder #(
    parameter int QW             = 32,
    parameter int XH             = 4,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [QW-1:0]    vector_i [XH],
    input  logic             valid_i,
    output logic             ready_o,
    output logic [QW-1:0]    vector_o [XH],
    output logic             valid_o_tg,
    input  logic             ready_i_tg,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] done_cnt_o
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_ERR
    } state_t;

    state_t            state_q;
    logic              s1_q, s2_q, s3_q;
    logic              ack_pulse;
    logic              pend_full_q;
    logic              pend_full_d;
    logic [QW-1:0]     pend_q [XH];
    logic [QW-1:0]     act_q  [XH];
    logic [3:0]        setup_q;
    logic [WD_W-1:0]   wd_q;
    logic              tg_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              load;
    logic              accept;

    assign ack_pulse = s2_q ^ s3_q;
    assign load      = (state_q == S_IDLE) && pend_full_q;
    // The buffer may be refilled on the same edge it drains into act_q.
    assign ready_o   = !err_q && (state_q != S_ERR) && (!pend_full_q || load);
    assign accept    = valid_i && ready_o;

    always_comb begin
        pend_full_d = pend_full_q;
        if (accept) begin
            pend_full_d = 1'b1;
        end else if (load) begin
            pend_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            pend_full_q <= 1'b0;
            pend_q      <= '{default: '0};
        end else begin
            s1_q        <= ready_i_tg;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            pend_full_q <= pend_full_d;
            if (accept) begin
                pend_q <= vector_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            act_q   <= '{default: '0};
            setup_q <= '0;
            wd_q    <= '0;
            tg_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= err_q | (state_q == S_ERR);
            case (state_q)
                S_IDLE: begin
                    if (pend_full_q) begin
                        act_q   <= pend_q;
                        setup_q <= '0;
                    end
                    // An ack with no toggle outstanding means the two sides lost step.
                    if (ack_pulse) begin
                        state_q <= S_ERR;
                    end else if (pend_full_q) begin
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (ack_pulse) begin
                        state_q <= S_ERR;
                    end else if (setup_q == SETUP_LAST) begin
                        tg_q    <= ~tg_q;
                        wd_q    <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        setup_q <= setup_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ack_pulse) begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= S_IDLE;
                    end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
                        state_q <= S_ERR;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_ERR;
                end
            endcase
        end
    end

    assign vector_o   = act_q;
    assign valid_o_tg = tg_q;
    assign busy_o     = (state_q != S_IDLE);
    assign err_o      = err_q;
    assign done_cnt_o = cnt_q;

endmodule

// File: tb/tb_xbar_feeder.sv
`timescale 1ns/1ps
// Bench for xbar_feeder: two instances (default and short-timeout/narrow-counter) against a
// timestamp-based transfer model, plus directed scenarios with hand-derived cycle counts.
module tb_xbar_feeder;
    localparam int QW = 32;
    localparam int XH = 4;
    localparam int NI = 2;
    localparam int SU_A = 1, TMO_A = 1024;
    localparam int SU_B = 3, TMO_B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn_a, rstn_b, valid_a, valid_b;
    logic [QW-1:0] vin_a [XH];
    logic [QW-1:0] vin_b [XH];
    logic [QW-1:0] vout_a [XH];
    logic [QW-1:0] vout_b [XH];
    logic          rdy_a, rdy_b, tg_a, tg_b, busy_a, busy_b, err_a, err_b;
    logic          rtg_a, rtg_b;
    logic [15:0]   cnt_a;
    logic [3:0]    cnt_b;

    logic          man_tg  [NI];
    logic          auto_tg [NI];
    logic          echo_en [NI];
    int            echo_lo [NI];
    int            echo_hi [NI];
    logic          r_seen  [NI];
    logic          r_pend  [NI];
    int            r_left  [NI];
    int            echo_cnt[NI];

    assign rtg_a = auto_tg[0] ^ man_tg[0];
    assign rtg_b = auto_tg[1] ^ man_tg[1];

    xbar_feeder #(.QW(QW), .XH(XH), .SETUP_CYCLES(SU_A), .TIMEOUT_CYCLES(TMO_A), .CNT_W(16)) dut_a (
        .clk(clk), .rstn(rstn_a), .vector_i(vin_a), .valid_i(valid_a), .ready_o(rdy_a),
        .vector_o(vout_a), .valid_o_tg(tg_a), .ready_i_tg(rtg_a), .busy_o(busy_a),
        .err_o(err_a), .done_cnt_o(cnt_a));

    xbar_feeder #(.QW(QW), .XH(XH), .SETUP_CYCLES(SU_B), .TIMEOUT_CYCLES(TMO_B), .CNT_W(4)) dut_b (
        .clk(clk), .rstn(rstn_b), .vector_i(vin_b), .valid_i(valid_b), .ready_o(rdy_b),
        .vector_o(vout_b), .valid_o_tg(tg_b), .ready_i_tg(rtg_b), .busy_o(busy_b),
        .err_o(err_b), .done_cnt_o(cnt_b));

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transfer model ----------------
    int            cyc = 0;
    bit            m_init     [NI];
    logic [31:0]   m_pend     [NI][XH];
    logic [31:0]   m_act      [NI][XH];
    bit            m_pfull    [NI];
    bit            m_inflight [NI];
    bit            m_toggled  [NI];
    int            m_load_cyc [NI];
    int            m_tog_cyc  [NI];
    bit            m_tg       [NI];
    bit            m_failed   [NI];
    bit            m_err_out  [NI];
    int            m_cnt      [NI];
    bit            m_h1 [NI], m_h2 [NI], m_h3 [NI];

    function automatic int setup_of(input int i);
        return (i == 0) ? SU_A : SU_B;
    endfunction
    function automatic int tmo_of(input int i);
        return (i == 0) ? TMO_A : TMO_B;
    endfunction
    function automatic logic [15:0] mask_of(input int i);
        return (i == 0) ? 16'hFFFF : 16'h000F;
    endfunction
    function automatic bit model_ready(input int i);
        return !m_err_out[i] && !m_failed[i] &&
               (!m_pfull[i] || (!m_inflight[i] && !m_failed[i]));
    endfunction

    task automatic model_step(input int i, input logic rst, input logic vld,
                              input logic [QW-1:0] v [XH], input logic rin);
        bit ack, take, drain, was_failed;
        if (!rst) begin
            m_init[i] = 1; m_pfull[i] = 0; m_inflight[i] = 0; m_toggled[i] = 0;
            m_tg[i] = 0; m_failed[i] = 0; m_err_out[i] = 0; m_cnt[i] = 0;
            m_h1[i] = 0; m_h2[i] = 0; m_h3[i] = 0;
            for (int k = 0; k < XH; k++) begin
                m_act[i][k] = '0;
                m_pend[i][k] = '0;
            end
            return;
        end
        ack = (m_h2[i] != m_h3[i]);
        m_h3[i] = m_h2[i]; m_h2[i] = m_h1[i]; m_h1[i] = rin;
        take = vld && model_ready(i);
        drain = 0;
        was_failed = m_failed[i];
        if (m_failed[i]) begin
            drain = 0;
        end else if (!m_inflight[i]) begin
            if (m_pfull[i]) begin
                for (int k = 0; k < XH; k++) m_act[i][k] = m_pend[i][k];
                m_load_cyc[i] = cyc;
                m_inflight[i] = 1;
                drain = 1;
            end
            if (ack) m_failed[i] = 1;
        end else if (!m_toggled[i]) begin
            if (ack) m_failed[i] = 1;
            else if (cyc - m_load_cyc[i] == setup_of(i)) begin
                m_tg[i] = !m_tg[i];
                m_toggled[i] = 1;
                m_tog_cyc[i] = cyc;
            end
        end else begin
            if (ack) begin
                m_cnt[i]++;
                m_inflight[i] = 0;
                m_toggled[i] = 0;
            end else if (tmo_of(i) != 0 && cyc - m_tog_cyc[i] == tmo_of(i)) begin
                m_failed[i] = 1;
            end
        end
        if (take) begin
            for (int k = 0; k < XH; k++) m_pend[i][k] = v[k];
            m_pfull[i] = 1;
        end else if (drain) begin
            m_pfull[i] = 0;
        end
        m_err_out[i] = m_err_out[i] | was_failed;
    endtask

    always @(posedge clk) begin
        model_step(0, rstn_a, valid_a, vin_a, rtg_a);
        model_step(1, rstn_b, valid_b, vin_b, rtg_b);
        cyc++;
    end

    task automatic check_outs(input int i, input logic [QW-1:0] vo [XH], input logic tg,
                              input logic rdy, input logic bsy, input logic er,
                              input logic [15:0] cn);
        if (!m_init[i]) return;
        for (int k = 0; k < XH; k++)
            chk($sformatf("dut%0d vector_o[%0d]", i, k), vo[k], m_act[i][k]);
        chk($sformatf("dut%0d valid_o_tg", i), 32'(tg), 32'(m_tg[i]));
        chk($sformatf("dut%0d ready_o", i), 32'(rdy), 32'(model_ready(i)));
        chk($sformatf("dut%0d busy_o", i), 32'(bsy), 32'(m_inflight[i] || m_failed[i]));
        chk($sformatf("dut%0d err_o", i), 32'(er), 32'(m_err_out[i]));
        chk($sformatf("dut%0d done_cnt_o", i), 32'(cn), 32'(16'(m_cnt[i]) & mask_of(i)));
    endtask

    logic [31:0] tgq [$];
    logic        prev_tg_a = 1'b0;

    always @(negedge clk) begin
        check_outs(0, vout_a, tg_a, rdy_a, busy_a, err_a, cnt_a);
        check_outs(1, vout_b, tg_b, rdy_b, busy_b, err_b, {12'b0, cnt_b});
        if (tg_a != prev_tg_a && busy_a) tgq.push_back(vout_a[0]);
        prev_tg_a = tg_a;
    end

    // ---------------- crossbar echo responder ----------------
    task automatic respond(input int i, input logic rst, input logic vtg);
        if (!rst) begin
            auto_tg[i] = 0; r_seen[i] = 0; r_pend[i] = 0;
            return;
        end
        if (r_pend[i]) begin
            if (r_left[i] == 0) begin
                auto_tg[i] = ~auto_tg[i];
                r_pend[i] = 0;
                echo_cnt[i]++;
            end else begin
                r_left[i]--;
            end
        end
        if (vtg !== r_seen[i]) begin
            r_seen[i] = vtg;
            if (echo_en[i]) begin
                r_pend[i] = 1;
                r_left[i] = $urandom_range(echo_hi[i], echo_lo[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            auto_tg[i] = 0; r_seen[i] = 0; r_pend[i] = 0; r_left[i] = 0; echo_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            #1;
            respond(0, rstn_a, tg_a);
            respond(1, rstn_b, tg_b);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut(input int i);
        if (i == 0) rstn_a = 0; else rstn_b = 0;
        man_tg[i] = 0;
        step(1);
        if (i == 0) rstn_a = 1; else rstn_b = 1;
    endtask

    task automatic check_reset_a(input string tag);
        for (int k = 0; k < XH; k++) chk({tag, " vector_o"}, vout_a[k], 32'h0);
        chk({tag, " valid_o_tg"}, 32'(tg_a), 0);
        chk({tag, " ready_o"}, 32'(rdy_a), 1);
        chk({tag, " busy_o"}, 32'(busy_a), 0);
        chk({tag, " err_o"}, 32'(err_a), 0);
        chk({tag, " done_cnt_o"}, 32'(cnt_a), 0);
    endtask

    task automatic offer(input int i, input logic [31:0] val, input bit rand_lanes);
        bit took;
        took = 0;
        for (int k = 0; k < XH; k++) begin
            logic [31:0] l;
            l = rand_lanes ? $urandom : val;
            if (i == 0) vin_a[k] = l; else vin_b[k] = l;
        end
        if (i == 0) valid_a = 1; else valid_b = 1;
        for (int c = 0; c < 100 && !took; c++) begin
            took = (i == 0) ? rdy_a : rdy_b;
            step(1);
        end
        if (i == 0) valid_a = 0; else valid_b = 0;
        chk($sformatf("dut%0d offer accepted", i), 32'(took), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] vals [3];
        int base;
        vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40400000;
        rstn_a = 0; rstn_b = 0; valid_a = 0; valid_b = 0;
        for (int k = 0; k < XH; k++) begin vin_a[k] = '0; vin_b[k] = '0; end
        for (int i = 0; i < NI; i++) begin
            man_tg[i] = 0; echo_en[i] = 0; echo_lo[i] = 0; echo_hi[i] = 0;
        end
        step(2);
        rstn_a = 1; rstn_b = 1;

        // single transfer
        reset_dut(0);
        check_reset_a("reset");
        offer(0, 32'h3F800000, 0);
        chk("single tg at accept+0", 32'(tg_a), 0);
        step(1);
        chk("single tg at accept+1", 32'(tg_a), 0);
        step(1);
        chk("single tg at accept+2", 32'(tg_a), 1);
        for (int c = 0; c < 50; c++) begin
            step(1);
            chk("single vector hold", vout_a[XH-1], 32'h3F800000);
        end
        man_tg[0] = ~man_tg[0];
        step(2);
        chk("single cnt echo+2", 32'(cnt_a), 0);
        step(1);
        chk("single cnt echo+3", 32'(cnt_a), 1);
        chk("single busy after ack", 32'(busy_a), 0);

        // back-to-back
        reset_dut(0);
        echo_en[0] = 1; echo_lo[0] = 5; echo_hi[0] = 5;
        base = tgq.size();
        for (int j = 0; j < 3; j++) begin
            offer(0, vals[j], 0);
            if (j == 1) chk("b2b ready drops after 2nd accept", 32'(rdy_a), 0);
        end
        for (int c = 0; c < 300 && cnt_a != 16'd3; c++) step(1);
        chk("b2b done_cnt", 32'(cnt_a), 3);
        chk("b2b valid_o_tg", 32'(tg_a), 1);
        chk("b2b toggle count", tgq.size() - base, 3);
        for (int j = 0; j < 3; j++)
            if (tgq.size() > base + j) chk($sformatf("b2b toggle %0d vector", j), tgq[base+j], vals[j]);
        echo_en[0] = 0;
        step(10);

        // spurious ack while idle
        reset_dut(0);
        step(2);
        man_tg[0] = ~man_tg[0];
        step(3);
        chk("spurious err at +3", 32'(err_a), 0);
        step(1);
        chk("spurious err at +4", 32'(err_a), 1);
        for (int k = 0; k < XH; k++) vin_a[k] = 32'h40800000;
        valid_a = 1;
        step(10);
        valid_a = 0;
        chk("spurious tg frozen", 32'(tg_a), 0);
        chk("spurious ready low", 32'(rdy_a), 0);
        chk("spurious busy in err", 32'(busy_a), 1);

        // reset mid-transfer
        reset_dut(0);
        offer(0, 32'h40A00000, 0);
        step(2);
        chk("midrst toggled", 32'(tg_a), 1);
        step(5);
        rstn_a = 0;
        man_tg[0] = 0;
        step(1);
        check_reset_a("midrst");
        rstn_a = 1;
        echo_en[0] = 1; echo_lo[0] = 3; echo_hi[0] = 3;
        offer(0, 32'h40C00000, 0);
        for (int c = 0; c < 100 && cnt_a != 16'd1; c++) step(1);
        chk("midrst new transfer cnt", 32'(cnt_a), 1);
        echo_en[0] = 0;
        step(5);

        // watchdog timeout on instance b
        reset_dut(1);
        offer(1, 32'h41000000, 0);
        for (int c = 0; c < 40 && !tg_b; c++) step(1);
        chk("timeout toggled", 32'(tg_b), 1);
        step(16);
        chk("timeout err at +16", 32'(err_b), 0);
        step(1);
        chk("timeout err at +17", 32'(err_b), 1);
        chk("timeout ready low", 32'(rdy_b), 0);
        man_tg[1] = ~man_tg[1];
        step(6);
        chk("timeout late ack cnt", 32'(cnt_b), 0);
        chk("timeout err sticky", 32'(err_b), 1);
        chk("timeout ready stays low", 32'(rdy_b), 0);

        // 4-bit counter wrap
        reset_dut(1);
        echo_en[1] = 1; echo_lo[1] = 0; echo_hi[1] = 0;
        base = echo_cnt[1];
        for (int j = 0; j < 17; j++) offer(1, 32'h0, 1);
        for (int c = 0; c < 600 && echo_cnt[1] != base + 17; c++) step(1);
        step(4);
        chk("wrap echoes", echo_cnt[1] - base, 17);
        chk("wrap done_cnt", 32'(cnt_b), 1);
        chk("wrap busy", 32'(busy_b), 0);

        // randomized traffic on both instances
        reset_dut(0);
        reset_dut(1);
        echo_en[0] = 1; echo_lo[0] = 0; echo_hi[0] = 12;
        echo_en[1] = 1; echo_lo[1] = 0; echo_hi[1] = 8;
        for (int c = 0; c < 400; c++) begin
            valid_a = 1'($urandom_range(0, 1));
            valid_b = 1'($urandom_range(0, 1));
            for (int k = 0; k < XH; k++) begin
                vin_a[k] = $urandom;
                vin_b[k] = $urandom;
            end
            step(1);
        end
        valid_a = 0; valid_b = 0;
        step(80);
        chk("random a no error", 32'(err_a), 0);
        chk("random b no error", 32'(err_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end
endmodule
